// File: rtl/ro_pkg.sv
// Shared definitions for the readout mux receive path: default sizes, event record, slot decode.
package ro_pkg;

  localparam int N_CH  = 8;
  localparam int CNT_W = 19;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic             pol;
    logic [CNT_W-1:0] ts;
  } ro_evt_t;

  // Number of consecutive ones from the LSB: the gray bit that toggles on s -> s+1.
  function automatic int ro_trailing_ones(input logic [31:0] s);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (run && s[i]) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/ro_evt_fifo.sv
// First-word-fall-through FIFO for event records; push is accepted when full only if a pop happens.
module ro_evt_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ro_demux_rx.sv
// Readout mux receiver: local slot counter, tag delay line, per-channel demux, event FIFO.
// Optional macro RO_DEMUX_DROPCNT_EN adds a saturating drop_cnt[7:0] output.
module ro_demux_rx
  import ro_pkg::ro_trailing_ones;
#(
  parameter int  N_CH       = ro_pkg::N_CH,
  parameter int  CNT_W      = ro_pkg::CNT_W,
  parameter int  PIPE_LAT   = 1,
  parameter int  FIFO_DEPTH = 16,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_master,
  input  logic             reset,
  input  logic             sync_in,
  input  logic             in_mux_eve,
  input  logic             in_mux_pol_eve,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CH_W-1:0]  ev_ch,
  output logic             ev_pol,
  output logic [CNT_W-1:0] ev_ts,
  output logic [N_CH-1:0]  ch_eve,
  output logic [N_CH-1:0]  ch_pol,
  output logic             armed,
  output logic             overflow,
`ifdef RO_DEMUX_DROPCNT_EN
  output logic [7:0]       drop_cnt,
`endif
  input  logic             ovf_clr
);

  typedef struct packed {
    logic             vld;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] ts;
  } tag_t;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic             pol;
    logic [CNT_W-1:0] ts;
  } evt_t;

  logic [CNT_W-1:0] cnt_reg;
  logic             armed_reg;
  logic             overflow_reg;
  int               tone;
  tag_t             tag_now, tag_smp;
  logic             smp_vld, push_req, pop, drop;
  logic             fifo_full, fifo_empty;
  evt_t             push_rec, head;

  always_ff @(posedge clk_master) begin
    if (reset) begin
      cnt_reg   <= '0;
      armed_reg <= 1'b0;
    end else if (sync_in) begin
      cnt_reg   <= '0;
      armed_reg <= 1'b1;
    end else if (armed_reg) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Slots whose toggling gray bit is beyond the channel range carry nothing.
  always_comb begin
    tone        = ro_trailing_ones(32'(cnt_reg));
    tag_now.vld = armed_reg && !sync_in && (tone < N_CH);
    tag_now.ch  = CH_W'(tone);
    tag_now.ts  = cnt_reg;
  end

  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign tag_smp = tag_now;
    end else begin : g_dly
      tag_t dly_reg [PIPE_LAT];
      always_ff @(posedge clk_master) begin
        if (reset || sync_in) begin
          for (int i = 0; i < PIPE_LAT; i++) dly_reg[i] <= '0;
        end else begin
          dly_reg[0] <= tag_now;
          for (int i = 1; i < PIPE_LAT; i++) dly_reg[i] <= dly_reg[i-1];
        end
      end
      assign tag_smp = dly_reg[PIPE_LAT-1];
    end
  endgenerate

  // A realignment cycle discards whatever tag is emerging at that moment.
  assign smp_vld  = tag_smp.vld && armed_reg && !sync_in;
  assign push_req = smp_vld && in_mux_eve;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic eve_reg, pol_reg;
      always_ff @(posedge clk_master) begin
        if (reset) begin
          eve_reg <= 1'b0;
          pol_reg <= 1'b0;
        end else if (smp_vld && (tag_smp.ch == CH_W'(gi))) begin
          eve_reg <= in_mux_eve;
          pol_reg <= in_mux_pol_eve;
        end
      end
      assign ch_eve[gi] = eve_reg;
      assign ch_pol[gi] = pol_reg;
    end
  endgenerate

  assign push_rec.ch  = tag_smp.ch;
  assign push_rec.pol = in_mux_pol_eve;
  assign push_rec.ts  = tag_smp.ts;

  ro_evt_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_master),
    .srst  (reset),
    .push  (push_req),
    .din   (push_rec),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;
  assign drop     = push_req && fifo_full && !pop;
  assign ev_ch    = ev_valid ? head.ch  : '0;
  assign ev_pol   = ev_valid ? head.pol : 1'b0;
  assign ev_ts    = ev_valid ? head.ts  : '0;
  assign armed    = armed_reg;
  assign overflow = overflow_reg;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk_master) begin
    if (reset)        overflow_reg <= 1'b0;
    else if (drop)    overflow_reg <= 1'b1;
    else if (ovf_clr) overflow_reg <= 1'b0;
  end

`ifdef RO_DEMUX_DROPCNT_EN
  logic [7:0] drop_cnt_reg;
  always_ff @(posedge clk_master) begin
    if (reset)                               drop_cnt_reg <= '0;
    else if (ovf_clr)                        drop_cnt_reg <= drop ? 8'd1 : 8'd0;
    else if (drop && (drop_cnt_reg != 8'hff)) drop_cnt_reg <= drop_cnt_reg + 8'd1;
  end
  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_ro_demux_rx.sv
// Directed bench for ro_demux_rx: slot schedule, demux latches, FIFO overflow, resync and counter wrap.
module tb_ro_demux_rx;

  logic clk_master = 1'b0;
  always #5 clk_master = ~clk_master;

  logic        reset, sync_in, in_mux_eve, in_mux_pol_eve, ev_ready, ovf_clr;
  logic        ev_valid, ev_pol, armed, overflow;
  logic [2:0]  ev_ch;
  logic [18:0] ev_ts;
  logic [7:0]  ch_eve, ch_pol;
  logic        ev_valid4, ev_pol4, armed4, overflow4;
  logic [2:0]  ev_ch4;
  logic [3:0]  ev_ts4;
  logic [7:0]  ch_eve4, ch_pol4;
`ifdef RO_DEMUX_DROPCNT_EN
  logic [7:0]  drop_cnt, drop_cnt4;
`endif

  ro_demux_rx #(.N_CH(8), .CNT_W(19), .PIPE_LAT(1), .FIFO_DEPTH(16)) dut (
    .clk_master(clk_master), .reset(reset), .sync_in(sync_in),
    .in_mux_eve(in_mux_eve), .in_mux_pol_eve(in_mux_pol_eve),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_pol(ev_pol), .ev_ts(ev_ts),
    .ch_eve(ch_eve), .ch_pol(ch_pol), .armed(armed), .overflow(overflow),
`ifdef RO_DEMUX_DROPCNT_EN
    .drop_cnt(drop_cnt),
`endif
    .ovf_clr(ovf_clr)
  );

  ro_demux_rx #(.N_CH(8), .CNT_W(4), .PIPE_LAT(1), .FIFO_DEPTH(16)) dut4 (
    .clk_master(clk_master), .reset(reset), .sync_in(sync_in),
    .in_mux_eve(in_mux_eve), .in_mux_pol_eve(in_mux_pol_eve),
    .ev_valid(ev_valid4), .ev_ready(ev_ready), .ev_ch(ev_ch4), .ev_pol(ev_pol4), .ev_ts(ev_ts4),
    .ch_eve(ch_eve4), .ch_pol(ch_pol4), .armed(armed4), .overflow(overflow4),
`ifdef RO_DEMUX_DROPCNT_EN
    .drop_cnt(drop_cnt4),
`endif
    .ovf_clr(ovf_clr)
  );

  typedef struct { int ch; int pol; int ts; } rec_t;
  rec_t q[$];
  rec_t q4[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  int   exp_ch [16] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 4};

  // Records leave the FIFO on the edge where valid&ready is seen.
  always @(posedge clk_master) begin
    rec_t r;
    if (ev_valid && ev_ready) begin
      r.ch = int'(ev_ch); r.pol = int'(ev_pol); r.ts = int'(ev_ts);
      q.push_back(r);
    end
    if (ev_valid4 && ev_ready) begin
      r.ch = int'(ev_ch4); r.pol = int'(ev_pol4); r.ts = int'(ev_ts4);
      q4.push_back(r);
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk_master);
  endtask

  task automatic do_reset();
    reset = 1'b1; sync_in = 1'b0; in_mux_eve = 1'b0; in_mux_pol_eve = 1'b0;
    ovf_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // After this returns, pins driven now belong to slot -1 (PIPE_LAT=1).
  task automatic start_sync();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
  endtask

  initial begin
    int n;
    ev_ready = 1'b1;
    do_reset();
    tick();
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_armed", armed, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ch_eve", ch_eve, 0);
    chk("rst_ev_ts", ev_ts, 0);

    // 1: every slot carries an event
    q.delete();
    start_sync();
    for (int s = -1; s <= 515; s++) begin
      if (s == 0) chk("t1_armed", armed, 1);
      in_mux_eve = 1'b1;
      tick();
    end
    in_mux_eve = 1'b0;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_ch%0d", i), q[i].ch, exp_ch[i]);
      chk($sformatf("t1_ts%0d", i), q[i].ts, i);
    end
    n = 0;
    foreach (q[i]) if (q[i].ts <= 511) n++;
    chk("t1_count_0_511", n, 510);
    n = 0;
    foreach (q[i]) if (q[i].ts == 255 || q[i].ts == 511) n++;
    chk("t1_idle_recs", n, 0);
    chk("t1_overflow", overflow, 0);

    // 2: single event in slot 3, then channel 2's next slot sends 0
    do_reset();
    q.delete();
    start_sync();
    for (int s = -1; s <= 14; s++) begin
      if (s == 11) begin
        chk("t2_ch_eve2_held", ch_eve[2], 1);
        chk("t2_ch_pol2_held", ch_pol[2], 1);
      end
      if (s == 12) begin
        chk("t2_ch_eve2_clr", ch_eve[2], 0);
        chk("t2_ch_pol2_clr", ch_pol[2], 0);
      end
      in_mux_eve     = (s == 3);
      in_mux_pol_eve = (s == 3);
      tick();
    end
    in_mux_eve = 1'b0; in_mux_pol_eve = 1'b0;
    chk("t2_nrec", q.size(), 1);
    if (q.size() >= 1) begin
      chk("t2_ch", q[0].ch, 2);
      chk("t2_pol", q[0].pol, 1);
      chk("t2_ts", q[0].ts, 3);
    end

    // 3: overflow with consumer stalled; slot 20 drop collides with ovf_clr
    do_reset();
    q.delete();
    ev_ready = 1'b0;
    start_sync();
    for (int s = -1; s <= 22; s++) begin
      if (s == 20) begin
        chk("t3_ovf_set", overflow, 1);
`ifdef RO_DEMUX_DROPCNT_EN
        chk("t3_drop_cnt4", drop_cnt, 4);
`endif
      end
      in_mux_eve     = (s >= 0 && s <= 20);
      in_mux_pol_eve = (s >= 0) && s[0];
      ovf_clr        = (s == 20);
      tick();
    end
    in_mux_eve = 1'b0; in_mux_pol_eve = 1'b0;
    chk("t3_ovf_setwins", overflow, 1);
`ifdef RO_DEMUX_DROPCNT_EN
    chk("t3_drop_cnt_clr_drop", drop_cnt, 1);
`endif
    chk("t3_head_ts_stalled", ev_ts, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    ev_ready = 1'b1;
    repeat (20) tick();
    chk("t3_nrec", q.size(), 16);
    n = 0;
    for (int i = 0; i < 16 && i < q.size(); i++)
      if (q[i].ts != i || q[i].ch != exp_ch[i] || q[i].pol != (i % 2)) n++;
    chk("t3_bad_recs", n, 0);

    // 4: full FIFO, push and pop in the same cycle
    do_reset();
    q.delete();
    ev_ready = 1'b0;
    start_sync();
    for (int s = -1; s <= 22; s++) begin
      in_mux_eve = (s >= 0 && s <= 15) || (s == 20);
      ev_ready   = (s == 20);
      tick();
    end
    in_mux_eve = 1'b0;
    chk("t4_overflow", overflow, 0);
    chk("t4_npop", q.size(), 1);
    chk("t4_head_ts", ev_ts, 1);
    ev_ready = 1'b1;
    repeat (20) tick();
    chk("t4_nrec", q.size(), 17);
    if (q.size() == 17) begin
      chk("t4_last_ts", q[16].ts, 20);
      chk("t4_last_ch", q[16].ch, 0);
      chk("t4_second_ts", q[1].ts, 1);
    end

    // 5: resync at cnt=100 discards the emerging slot
    do_reset();
    q.delete();
    start_sync();
    for (int s = -1; s <= 98; s++) begin
      in_mux_eve = 1'b1;
      tick();
    end
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    for (int s = -1; s <= 5; s++) tick();
    in_mux_eve = 1'b0;
    tick(); tick();
    chk("t5_armed", armed, 1);
    if (q.size() >= 101) begin
      chk("t5_last_old_ts", q[98].ts, 98);
      chk("t5_first_new_ts", q[99].ts, 0);
      chk("t5_first_new_ch", q[99].ch, 0);
      chk("t5_second_new_ts", q[100].ts, 1);
      chk("t5_second_new_ch", q[100].ch, 1);
    end else begin
      chk("t5_nrec", q.size(), 101);
    end

    // 6: 4-bit counter wraps without a gap; reset mid-burst
    do_reset();
    q4.delete();
    start_sync();
    for (int s = -1; s <= 39; s++) begin
      in_mux_eve = 1'b1;
      tick();
    end
    n = 0;
    for (int i = 0; i < 36 && i < q4.size(); i++) if (q4[i].ts != (i % 16)) n++;
    chk("t6_wrap_bad_ts", n, 0);
    chk("t6_nrec_min", (q4.size() >= 36), 1);
    if (q4.size() >= 32) begin
      chk("t6_ts15_ch", q4[15].ch, 4);
      chk("t6_wrap_ts", q4[16].ts, 0);
      chk("t6_wrap_ch", q4[16].ch, 0);
      chk("t6_ts31_ch", q4[31].ch, 4);
    end
    ev_ready = 1'b0;
    tick(); tick();
    chk("t6_valid_before_rst", ev_valid4, 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid4", ev_valid4, 0);
    chk("t6_rst_armed4", armed4, 0);
    chk("t6_rst_valid", ev_valid, 0);
    chk("t6_rst_armed", armed, 0);
    chk("t6_rst_ch_eve4", ch_eve4, 0);
    chk("t6_rst_ch_pol4", ch_pol4, 0);
    chk("t6_rst_ovf4", overflow4, 0);
`ifdef RO_DEMUX_DROPCNT_EN
    chk("t6_rst_drop_cnt4", drop_cnt4, 0);
`endif
    reset = 1'b0;
    in_mux_eve = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
